rvfi_commit_queue: RTL and testbench

Parametrised in-order commit buffer for RVFI monitor records. It decouples the pipeline writeback stage from the RVFI monitor and absorbs bursts when the monitor back-pressures. Each entry holds a 32-bit pc_rdata, a 32-bit pc_wdata and a generic payload; PAYLOAD_W covers the remaining RVFIMonPacket fields. It also counts retired instructions and can optionally check PC continuity between consecutive commits.

---
 rtl/rvfi_commit_queue.sv | 192 +++++++++++++++++++
 tb/tb_rvfi_commit_queue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_commit_queue.sv
// ---------------------------------------------------------------------------
// rvfi_commit_queue
//
// In-order commit buffer sitting between the pipeline writeback stage and the
// RVFI monitor. It absorbs bursts of retiring instructions while the monitor
// back-pressures, counts retired instructions and can optionally verify that
// consecutive commits form a continuous PC chain.
//
// Optional feature macro: RVFI_COMMIT_ORDER_CHECK_EN
//   defined   : PC-continuity checker drives the sticky order_err output
//   undefined : no checker logic, order_err tied to 0
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous active-low reset
//   in_valid      writeback offers a commit record
//   in_ready      queue can accept a record (not full)
//   in_pc_rdata   PC of the committing instruction
//   in_pc_wdata   next PC after the committing instruction
//   in_payload    remaining monitor fields (opaque)
//   out_valid     head entry available (not empty)
//   out_ready     monitor consumes the head entry
//   out_pc_rdata  head entry pc_rdata
//   out_pc_wdata  head entry pc_wdata
//   out_payload   head entry payload
//   flush         synchronous clear of all entries (beats push and pop)
//   count         current occupancy
//   full          count == DEPTH
//   empty         count == 0
//   retired       number of pops since reset, wraps silently
//   order_err     sticky PC-continuity error
// ---------------------------------------------------------------------------
module rvfi_commit_queue #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 256,
    parameter int CNT_W     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_pc_rdata,
    input  logic [31:0]                  in_pc_wdata,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_pc_rdata,
    output logic [31:0]                  out_pc_wdata,
    output logic [PAYLOAD_W-1:0]         out_payload,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [CNT_W-1:0]             retired,
    output logic                         order_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // Storage. Reset to zero so the head data is never X, which rules out a
    // block-RAM mapping; the array is small enough to live in fabric flops.
    logic [31:0]          pc_rdata_mem_reg [DEPTH];
    logic [31:0]          pc_wdata_mem_reg [DEPTH];
    logic [PAYLOAD_W-1:0] payload_mem_reg  [DEPTH];

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [OCC_W-1:0] count_reg;
    logic [CNT_W-1:0] retired_reg;

    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [OCC_W-1:0] count_next;

    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Handshake qualification
    // ------------------------------------------------------------------
    assign full      = (count_reg == OCC_FULL);
    assign empty     = (count_reg == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;

    // Flush wins: a transfer that coincides with it simply never happened.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Head data straight out of storage; no fall-through path from the input.
    assign out_pc_rdata = pc_rdata_mem_reg[head_reg];
    assign out_pc_wdata = pc_wdata_mem_reg[head_reg];
    assign out_payload  = payload_mem_reg[head_reg];

    assign count   = count_reg;
    assign retired = retired_reg;

    // ------------------------------------------------------------------
    // Pointer / occupancy next-state
    // ------------------------------------------------------------------
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (pop) begin
                head_next = (head_reg == PTR_LAST) ? '0 : head_reg + 1'b1;
            end
            if (push) begin
                tail_next = (tail_reg == PTR_LAST) ? '0 : tail_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            retired_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            if (pop) begin
                retired_reg <= retired_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_rdata_mem_reg[i] <= '0;
                pc_wdata_mem_reg[i] <= '0;
                payload_mem_reg[i]  <= '0;
            end
        end else if (push) begin
            pc_rdata_mem_reg[tail_reg] <= in_pc_rdata;
            pc_wdata_mem_reg[tail_reg] <= in_pc_wdata;
            payload_mem_reg[tail_reg]  <= in_payload;
        end
    end

    // ------------------------------------------------------------------
    // PC continuity checker
    // ------------------------------------------------------------------
`ifdef RVFI_COMMIT_ORDER_CHECK_EN
    logic [31:0] prev_wdata_reg;
    logic        have_prev_reg;
    logic        order_err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_wdata_reg <= '0;
            have_prev_reg  <= 1'b0;
            order_err_reg  <= 1'b0;
        end else if (flush) begin
            // The stream restarts after a flush, so the next pop has no
            // predecessor to compare against.
            have_prev_reg <= 1'b0;
        end else if (pop) begin
            if (have_prev_reg && (out_pc_rdata != prev_wdata_reg)) begin
                order_err_reg <= 1'b1;
            end
            prev_wdata_reg <= out_pc_wdata;
            have_prev_reg  <= 1'b1;
        end
    end

    assign order_err = order_err_reg;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_commit_queue.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for rvfi_commit_queue (default parameters).
// Inputs are driven 1 ns after the rising edge and outputs are sampled there,
// well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_rvfi_commit_queue;

    localparam int DEPTH     = 8;
    localparam int PAYLOAD_W = 256;
    localparam int CNT_W     = 64;

`ifdef RVFI_COMMIT_ORDER_CHECK_EN
    localparam logic ORDER_ERR_EXP = 1'b1;
`else
    localparam logic ORDER_ERR_EXP = 1'b0;
`endif

    logic                       clk;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic [31:0]                in_pc_rdata;
    logic [31:0]                in_pc_wdata;
    logic [PAYLOAD_W-1:0]       in_payload;
    logic                       out_valid;
    logic                       out_ready;
    logic [31:0]                out_pc_rdata;
    logic [31:0]                out_pc_wdata;
    logic [PAYLOAD_W-1:0]       out_payload;
    logic                       flush;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       full;
    logic                       empty;
    logic [CNT_W-1:0]           retired;
    logic                       order_err;

    int checks_cnt;
    int fail_cnt;

    rvfi_commit_queue #(
        .DEPTH     (DEPTH),
        .PAYLOAD_W (PAYLOAD_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc_rdata  (in_pc_rdata),
        .in_pc_wdata  (in_pc_wdata),
        .in_payload   (in_payload),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc_rdata (out_pc_rdata),
        .out_pc_wdata (out_pc_wdata),
        .out_payload  (out_payload),
        .flush        (flush),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .retired      (retired),
        .order_err    (order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic [31:0] npc);
        in_pc_rdata = pc;
        in_pc_wdata = npc;
        in_payload  = '0;
        in_payload[63:0] = {~pc, pc};
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] npc);
        in_valid = 1'b1;
        set_rec(pc, npc);
        step();
        in_valid = 1'b0;
        $display("push pc_rdata=0x%08h pc_wdata=0x%08h count=%0d", pc, npc, count);
    endtask

    // Pops the head, checking it against the expected record first.
    task automatic pop_expect(input string tag, input logic [31:0] pc, input logic [31:0] npc);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_rdata"}, 64'(out_pc_rdata), 64'(pc));
        check_eq({tag, "_wdata"}, 64'(out_pc_wdata), 64'(npc));
        check_eq({tag, "_payload"}, out_payload[63:0], {~pc, pc});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("pop  pc_rdata=0x%08h expected=0x%08h count=%0d", out_pc_rdata, pc, count);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
    endtask

    initial begin
        int q[$];
        int next_k;
        int cyc;
        bit exp_push;
        bit exp_pop;
        logic [31:0] pc;

        checks_cnt  = 0;
        fail_cnt    = 0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        in_pc_rdata = '0;
        in_pc_wdata = '0;
        in_payload  = '0;

        // ---------------- reset then idle ----------------
        do_reset();
        check_eq("rst_empty",     64'(empty),     64'd1);
        check_eq("rst_full",      64'(full),      64'd0);
        check_eq("rst_count",     64'(count),     64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_retired",   retired,        64'd0);
        check_eq("rst_order_err", 64'(order_err), 64'd0);
        check_eq("rst_out_rdata", 64'(out_pc_rdata), 64'd0);

        // ---------------- three-record burst ----------------
        in_valid = 1'b1;
        set_rec(32'h60, 32'h64);
        step();
        $display("push pc_rdata=0x00000060 pc_wdata=0x00000064 count=%0d", count);
        check_eq("lat_out_valid", 64'(out_valid), 64'd1);
        check_eq("lat_out_rdata", 64'(out_pc_rdata), 64'h60);
        push_one(32'h64, 32'h68);
        push_one(32'h68, 32'h6c);
        check_eq("burst_count", 64'(count), 64'd3);
        pop_expect("burst0", 32'h60, 32'h64);
        pop_expect("burst1", 32'h64, 32'h68);
        pop_expect("burst2", 32'h68, 32'h6c);
        check_eq("burst_retired", retired, 64'd3);
        check_eq("burst_empty", 64'(empty), 64'd1);

        // Break the PC chain cleanly before the next record stream.
        flush = 1'b1;
        step();
        flush = 1'b0;

        // ---------------- fill, full-stall, wrap ----------------
        for (int k = 0; k < DEPTH; k++) begin
            push_one(32'h1000 + 32'(4 * k), 32'h1004 + 32'(4 * k));
            q.push_back(k);
        end
        check_eq("fill_full",     64'(full),     64'd1);
        check_eq("fill_in_ready", 64'(in_ready), 64'd0);
        check_eq("fill_count",    64'(count),    64'd8);

        // Ninth record offered while a pop happens: must be refused.
        in_valid  = 1'b1;
        set_rec(32'h1000 + 32'(4 * 8), 32'h1004 + 32'(4 * 8));
        out_ready = 1'b1;
        check_eq("full_head", 64'(out_pc_rdata), 64'h1000);
        step();
        void'(q.pop_front());
        check_eq("full_pop_count", 64'(count), 64'd7);
        $display("pop  pc_rdata=0x00001000 with 9th push refused count=%0d", count);

        next_k = 8;
        cyc    = 0;
        while (next_k < 20 && cyc < 200) begin
            pc        = 32'h1000 + 32'(4 * next_k);
            in_valid  = 1'b1;
            set_rec(pc, pc + 32'd4);
            out_ready = ((cyc % 3) != 0);
            exp_push  = (q.size() < DEPTH);
            exp_pop   = out_ready && (q.size() > 0);
            check_eq("wrap_in_ready", 64'(in_ready), 64'(exp_push));
            if (exp_pop) begin
                check_eq("wrap_head", 64'(out_pc_rdata), 64'(32'h1000 + 32'(4 * q[0])));
            end
            step();
            if (exp_pop) begin
                $display("pop  pc_rdata=0x%08h", 32'h1000 + 32'(4 * q[0]));
                void'(q.pop_front());
            end
            if (exp_push) begin
                $display("push pc_rdata=0x%08h", pc);
                q.push_back(next_k);
                next_k++;
            end
            check_eq("wrap_count", 64'(count), 64'(q.size()));
            cyc++;
        end
        check_eq("wrap_no_timeout", 64'(next_k), 64'd20);
        in_valid = 1'b0;

        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            pc = 32'h1000 + 32'(4 * q[0]);
            pop_expect("drain", pc, pc + 32'd4);
            void'(q.pop_front());
            cyc++;
        end
        check_eq("drain_empty",   64'(empty), 64'd1);
        check_eq("drain_retired", retired,    64'd23);

        // ---------------- flush with concurrent push and pop ----------------
        for (int k = 0; k < 5; k++) begin
            push_one(32'h2000 + 32'(4 * k), 32'h2004 + 32'(4 * k));
        end
        check_eq("pre_flush_count", 64'(count), 64'd5);
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set_rec(32'h3000, 32'h3004);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        $display("flush count=%0d retired=%0d", count, retired);
        check_eq("flush_count",   64'(count), 64'd0);
        check_eq("flush_empty",   64'(empty), 64'd1);
        check_eq("flush_retired", retired,    64'd23);
        check_eq("flush_order_err", 64'(order_err), 64'd0);

        // ---------------- PC discontinuity ----------------
        push_one(32'h60, 32'h64);
        push_one(32'h70, 32'h74);
        pop_expect("disc0", 32'h60, 32'h64);
        check_eq("disc_err_first", 64'(order_err), 64'd0);
        pop_expect("disc1", 32'h70, 32'h74);
        check_eq("disc_err_set", 64'(order_err), 64'(ORDER_ERR_EXP));
        repeat (3) step();
        check_eq("disc_err_sticky", 64'(order_err), 64'(ORDER_ERR_EXP));
        check_eq("disc_retired", retired, 64'd25);

        // ---------------- same discontinuity split by a flush ----------------
        do_reset();
        check_eq("rst2_order_err", 64'(order_err), 64'd0);
        check_eq("rst2_retired",   retired,        64'd0);
        push_one(32'h60, 32'h64);
        pop_expect("fl_disc0", 32'h60, 32'h64);
        flush = 1'b1;
        step();
        flush = 1'b0;
        push_one(32'h70, 32'h74);
        pop_expect("fl_disc1", 32'h70, 32'h74);
        step();
        check_eq("fl_disc_err", 64'(order_err), 64'd0);
        check_eq("fl_disc_retired", retired, 64'd2);

        // ---------------- asynchronous reset mid-burst ----------------
        push_one(32'h500, 32'h504);
        push_one(32'h504, 32'h508);
        in_valid = 1'b1;
        set_rec(32'h508, 32'h50c);
        step();
        check_eq("mid_count", 64'(count), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        $display("async reset asserted between edges count=%0d", count);
        check_eq("arst_count",     64'(count),     64'd0);
        check_eq("arst_empty",     64'(empty),     64'd1);
        check_eq("arst_full",      64'(full),      64'd0);
        check_eq("arst_in_ready",  64'(in_ready),  64'd1);
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_retired",   retired,        64'd0);
        check_eq("arst_order_err", 64'(order_err), 64'd0);
        check_eq("arst_out_rdata", 64'(out_pc_rdata), 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check_eq("post_rst_count", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
